// File: rtl/alk_splatch_if.sv
// alk_splatch_if: ROT-decoder-to-S/P-latch bus.
// Carries the ROT micro-op field, modsp_l strobe and W-bus load data into the
// latch unit, and the S/P latch values plus run status back out.
//   master : ROT decoder side (drives rot_h, modsp_l, wbus_h)
//   slave  : alk_splatch side (drives s_h, p_h, szero_h, step_h, stall_h)
// With ALK_SP_PARITY_EN defined, also carries pinj_h (in) and perr_h (out).
interface alk_splatch_if #(
  parameter int unsigned SPW = 6
);
  logic [5:0]     rot_h;
  logic           modsp_l;
  logic [SPW-1:0] wbus_h;
  logic [SPW-1:0] s_h;
  logic [SPW-1:0] p_h;
  logic           szero_h;
  logic           step_h;
  logic           stall_h;
`ifdef ALK_SP_PARITY_EN
  logic           pinj_h;
  logic           perr_h;
`endif

  modport master (
    output rot_h, modsp_l, wbus_h,
`ifdef ALK_SP_PARITY_EN
    output pinj_h,
    input  perr_h,
`endif
    input  s_h, p_h, szero_h, step_h, stall_h
  );

  modport slave (
    input  rot_h, modsp_l, wbus_h,
`ifdef ALK_SP_PARITY_EN
    input  pinj_h,
    output perr_h,
`endif
    output s_h, p_h, szero_h, step_h, stall_h
  );
endinterface

// File: rtl/alk_splatch.sv
// alk_splatch: S (shift count) / P (position) latch unit of the DC615 ALK
// datapath. Loads, steps and swaps S/P on ROT micro-ops gated by modsp_l, and
// runs a count-down sequencer (ROT 3F) that steps the rotator S times while
// stalling the microsequencer.
// Ports:
//   clk_h    : chip clock, rising edge
//   reset_h  : asynchronous active-high reset
//   bus      : alk_splatch_if.slave (rot_h, modsp_l, wbus_h in;
//              s_h, p_h, szero_h, step_h, stall_h out)
// Optional feature macro ALK_SP_PARITY_EN: odd parity kept on S and P, with
// sticky error output perr_h and write-parity injection input pinj_h.
module alk_splatch #(
  parameter int unsigned SPW    = 6,
  parameter int unsigned CNTMAX = 63
) (
  input  logic         clk_h,
  input  logic         reset_h,
  alk_splatch_if.slave bus
);

  localparam logic [5:0] ROT_LD_S  = 6'h27;
  localparam logic [5:0] ROT_LD_P  = 6'h2D;
  localparam logic [5:0] ROT_DEC_S = 6'h2F;
  localparam logic [5:0] ROT_INC_P = 6'h3B;
  localparam logic [5:0] ROT_SWAP  = 6'h3D;
  localparam logic [5:0] ROT_RUN   = 6'h3F;

  // Largest S value; decrementing zero wraps here.
  localparam logic [SPW-1:0] S_MAX = SPW'(CNTMAX);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [SPW-1:0] s_q, s_d;
  logic [SPW-1:0] p_q, p_d;
  logic           step_q, step_d;
  logic           stall_q, stall_d;
  logic           s_wr;
  logic           p_wr;

  // Next-state and latch update logic.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    p_d     = p_q;
    s_wr    = 1'b0;
    p_wr    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.modsp_l) begin
          case (bus.rot_h)
            ROT_LD_S: begin
              s_d  = bus.wbus_h;
              s_wr = 1'b1;
            end
            ROT_LD_P: begin
              p_d  = bus.wbus_h;
              p_wr = 1'b1;
            end
            ROT_DEC_S: begin
              s_d  = (s_q == '0) ? S_MAX : s_q - SPW'(1);
              s_wr = 1'b1;
            end
            ROT_INC_P: begin
              p_d  = p_q + SPW'(1);
              p_wr = 1'b1;
            end
            ROT_SWAP: begin
              s_d  = p_q;
              p_d  = s_q;
              s_wr = 1'b1;
              p_wr = 1'b1;
            end
            ROT_RUN: begin
              // A zero count is a zero-length run: stay idle.
              if (s_q != '0) begin
                state_d = RUN;
              end
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        // Inputs are ignored; S counts itself down to zero.
        s_wr = 1'b1;
        if (s_q <= SPW'(1)) begin
          s_d     = '0;
          state_d = IDLE;
        end else begin
          s_d = s_q - SPW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    step_d  = (state_d == RUN);
    stall_d = (state_d == RUN);
  end

  // State and latch registers.
  always_ff @(posedge clk_h or posedge reset_h) begin
    if (reset_h) begin
      state_q <= IDLE;
      s_q     <= '0;
      p_q     <= '0;
      step_q  <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      p_q     <= p_d;
      step_q  <= step_d;
      stall_q <= stall_d;
    end
  end

  assign bus.s_h     = s_q;
  assign bus.p_h     = p_q;
  assign bus.szero_h = (s_q == '0);
  assign bus.step_h  = step_q;
  assign bus.stall_h = stall_q;

`ifdef ALK_SP_PARITY_EN
  logic s_par_q, s_par_d;
  logic p_par_q, p_par_d;
  logic perr_q, perr_d;

  // Odd parity regenerated on each write; pinj_h flips it for error injection.
  always_comb begin
    s_par_d = s_wr ? ((~^s_d) ^ bus.pinj_h) : s_par_q;
    p_par_d = p_wr ? ((~^p_d) ^ bus.pinj_h) : p_par_q;
    perr_d  = perr_q | (s_par_q != (~^s_q)) | (p_par_q != (~^p_q));
  end

  // Reset parity matches the all-zero latches (odd parity of 0 is 1).
  always_ff @(posedge clk_h or posedge reset_h) begin
    if (reset_h) begin
      s_par_q <= 1'b1;
      p_par_q <= 1'b1;
      perr_q  <= 1'b0;
    end else begin
      s_par_q <= s_par_d;
      p_par_q <= p_par_d;
      perr_q  <= perr_d;
    end
  end

  assign bus.perr_h = perr_q;
`else
  logic unused_wr;
  assign unused_wr = s_wr ^ p_wr;
`endif

endmodule

// File: tb/tb_alk_splatch.sv
// tb_alk_splatch: randomized, self-checking bench for alk_splatch. A
// behavioural model (S/P values plus a remaining-steps count) predicts every
// output; a negedge compare process checks it each cycle, and directed
// scenarios pin the model with literal expectations.
module tb_alk_splatch;
  localparam int SPW = 6;

  logic clk_h   = 1'b0;
  logic reset_h = 1'b1;
  always #5 clk_h = ~clk_h;

  alk_splatch_if #(.SPW(SPW)) bus ();

  alk_splatch #(.SPW(SPW), .CNTMAX(63)) dut (
    .clk_h   (clk_h),
    .reset_h (reset_h),
    .bus     (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
  endtask

  // Behavioural model: m_left is the number of step cycles still to come.
  logic [5:0] m_s, m_p;
  int         m_left;
  bit         m_perr, m_bad_s, m_bad_p;

  function automatic bit legal_rot(input logic [5:0] r);
    return r inside {6'h27, 6'h2D, 6'h2F, 6'h3B, 6'h3D, 6'h3F};
  endfunction

  always @(posedge clk_h or posedge reset_h) begin
    if (reset_h) begin
      m_s = '0; m_p = '0; m_left = 0;
      m_perr = 1'b0; m_bad_s = 1'b0; m_bad_p = 1'b0;
    end else begin
      bit ws, wp, inj;
      ws = 1'b0; wp = 1'b0;
`ifdef ALK_SP_PARITY_EN
      inj = bus.pinj_h;
`else
      inj = 1'b0;
`endif
      m_perr = m_perr | m_bad_s | m_bad_p;
      if (m_left > 0) begin
        m_left = m_left - 1;
        m_s = 6'(m_left);
        ws = 1'b1;
      end else if (!bus.modsp_l) begin
        case (bus.rot_h)
          6'h27: begin m_s = bus.wbus_h; ws = 1'b1; end
          6'h2D: begin m_p = bus.wbus_h; wp = 1'b1; end
          6'h2F: begin m_s = m_s - 6'd1; ws = 1'b1; end
          6'h3B: begin m_p = m_p + 6'd1; wp = 1'b1; end
          6'h3D: begin {m_s, m_p} = {m_p, m_s}; ws = 1'b1; wp = 1'b1; end
          6'h3F: m_left = int'(m_s);
          default: ;
        endcase
      end
      if (ws) m_bad_s = inj;
      if (wp) m_bad_p = inj;
    end
  end

  // The decoder never issues modsp_l=0 with an unlisted ROT code.
  always @(posedge clk_h) begin
    if (!reset_h && !bus.modsp_l)
      assert (legal_rot(bus.rot_h)) else $error("FAIL illegal_rot: rot_h=%h with modsp_l=0", bus.rot_h);
  end

  // Per-cycle compare against the model.
  always @(negedge clk_h) begin
    if (cmp_en && !reset_h) begin
      check("s_h",     int'(bus.s_h),     int'(m_s));
      check("p_h",     int'(bus.p_h),     int'(m_p));
      check("szero_h", int'(bus.szero_h), int'(m_s == 6'd0));
      check("stall_h", int'(bus.stall_h), int'(m_left != 0));
      check("step_h",  int'(bus.step_h),  int'(m_left != 0));
`ifdef ALK_SP_PARITY_EN
      check("perr_h",  int'(bus.perr_h),  int'(m_perr));
`endif
    end
  end

  // Present one op for a single edge, return at the following negedge.
  task automatic do_op(input logic [5:0] r, input logic [5:0] w);
    bus.modsp_l = 1'b0;
    bus.rot_h   = r;
    bus.wbus_h  = w;
    @(negedge clk_h);
    bus.modsp_l = 1'b1;
  endtask

  task automatic pulse_reset_checked(input string tag);
    #2 reset_h = 1'b1;
    #1;
    check({tag, "_s"},     int'(bus.s_h),     0);
    check({tag, "_p"},     int'(bus.p_h),     0);
    check({tag, "_szero"}, int'(bus.szero_h), 1);
    check({tag, "_stall"}, int'(bus.stall_h), 0);
    check({tag, "_step"},  int'(bus.step_h),  0);
    bus.modsp_l = 1'b1;
    #1 reset_h = 1'b0;
  endtask

  initial begin
    int cnt;
    int seen;
    int vals[4];
    logic [5:0] legal[6];
    legal[0] = 6'h27; legal[1] = 6'h2D; legal[2] = 6'h2F;
    legal[3] = 6'h3B; legal[4] = 6'h3D; legal[5] = 6'h3F;

    bus.modsp_l = 1'b1;
    bus.rot_h   = 6'h00;
    bus.wbus_h  = 6'h00;
`ifdef ALK_SP_PARITY_EN
    bus.pinj_h  = 1'b0;
`endif
    reset_h = 1'b1;
    repeat (2) @(negedge clk_h);
    check("rst_s",     int'(bus.s_h),     0);
    check("rst_p",     int'(bus.p_h),     0);
    check("rst_szero", int'(bus.szero_h), 1);
    check("rst_stall", int'(bus.stall_h), 0);
    #1 reset_h = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk_h);

    // Load / step with wraps.
    do_op(6'h27, 6'h05); check("ld_s", int'(bus.s_h), 5);
    do_op(6'h2D, 6'h3F); check("ld_p", int'(bus.p_h), 63);
    do_op(6'h3B, 6'h00); check("inc_p_wrap", int'(bus.p_h), 0);
    do_op(6'h2F, 6'h00); check("dec_s", int'(bus.s_h), 4);
    do_op(6'h27, 6'h00); do_op(6'h2F, 6'h00);
    check("dec_s_wrap", int'(bus.s_h), 63);

    // Asynchronous reset mid-cycle.
    do_op(6'h2D, 6'h09);
    pulse_reset_checked("areset");
    @(negedge clk_h);

    // Swap.
    do_op(6'h27, 6'h12); do_op(6'h2D, 6'h2A); do_op(6'h3D, 6'h00);
    check("swap_s", int'(bus.s_h), 8'h2A);
    check("swap_p", int'(bus.p_h), 8'h12);

    // Count-down from 3.
    do_op(6'h27, 6'h03); do_op(6'h3F, 6'h00);
    cnt = 0;
    while (bus.stall_h && cnt < 100) begin
      if (cnt < 4) vals[cnt] = int'(bus.s_h);
      cnt++;
      @(negedge clk_h);
    end
    check("run3_len", cnt, 3);
    check("run3_s0", vals[0], 3);
    check("run3_s1", vals[1], 2);
    check("run3_s2", vals[2], 1);
    check("run3_end_s", int'(bus.s_h), 0);
    check("run3_p", int'(bus.p_h), 8'h12);

    // Zero-length run.
    do_op(6'h27, 6'h00); do_op(6'h3F, 6'h00);
    seen = 0;
    repeat (3) begin
      if (bus.stall_h) seen++;
      @(negedge clk_h);
    end
    check("run0_stall", seen, 0);

    // Inputs ignored during a run, then reset aborts it at step 4.
    do_op(6'h27, 6'h0A);
    bus.modsp_l = 1'b0; bus.rot_h = 6'h3F;
    @(negedge clk_h);
    check("run10_s_first", int'(bus.s_h), 10);
    bus.rot_h = 6'h27; bus.wbus_h = 6'h01;
    repeat (3) @(negedge clk_h);
    check("run10_step4_s", int'(bus.s_h), 7);
    check("run10_step4_stall", int'(bus.stall_h), 1);
    pulse_reset_checked("abort");
    @(negedge clk_h);

`ifdef ALK_SP_PARITY_EN
    // Parity injection: sticky error until reset.
    bus.pinj_h = 1'b1;
    do_op(6'h27, 6'h07);
    bus.pinj_h = 1'b0;
    @(negedge clk_h);
    check("perr_set", int'(bus.perr_h), 1);
    repeat (3) @(negedge clk_h);
    check("perr_held", int'(bus.perr_h), 1);
    #2 reset_h = 1'b1;
    #1 check("perr_clr", int'(bus.perr_h), 0);
    #1 reset_h = 1'b0;
    @(negedge clk_h);
`endif

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2 reset_h = 1'b1;
        #2 reset_h = 1'b0;
      end
      if ($urandom_range(0, 9) < 6) begin
        bus.modsp_l = 1'b0;
        bus.rot_h   = legal[$urandom_range(0, 5)];
      end else begin
        bus.modsp_l = 1'b1;
        bus.rot_h   = 6'($urandom_range(0, 63));
      end
      bus.wbus_h = 6'($urandom_range(0, 63));
`ifdef ALK_SP_PARITY_EN
      bus.pinj_h = ($urandom_range(0, 49) == 0);
`endif
      @(negedge clk_h);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alk_splatch.md
Name: alk_splatch

Overview:
- S (shift count) and P (position) latch unit of the DC615 ALK datapath chip.
- Sits directly downstream of the ROT micro-op decoder and consumes its modsp_l strobe together with the raw ROT field.
- Holds, loads, steps and counts the S/P latches that drive the rotator and field-extract logic.
- Includes a multi-cycle count-down sequencer used for iterative shift micro-ops.

Parameters:
- SPW, 6, width of the S and P latches in bits.
- CNTMAX, 63, maximum number of step cycles a count-down run may take; it equals the largest S value.

Ports:
- clk_h  input  1  chip clock; all state updates on the rising edge.
- reset_h  input  1  asynchronous, active-high reset.
- rot_h  input  6  ROT micro-op field for the current microcycle.
- modsp_l  input  1  low when the ROT field selects an S/P-modifying function (ROT 27, 2D, 2F, 3B, 3D or 3F).
- wbus_h  input  SPW  load data from the W bus.
- s_h  output  SPW  current S latch value.
- p_h  output  SPW  current P latch value.
- szero_h  output  1  high when S == 0.
- step_h  output  1  one rotator shift step in this cycle (count-down run active).
- stall_h  output  1  high while a count-down run is active; holds off the microsequencer.

Behaviour:
- Reset (asynchronous, reset_h high): S=0, P=0, FSM=IDLE, step_h=0, stall_h=0. szero_h=1.
- Assertion of reset mid-run aborts the run immediately; there is no completion step.
- FSM states:
  - IDLE: ops decoded as below.
  - RUN: count-down in progress.
- IDLE with modsp_l=1: S and P hold their values.
- IDLE with modsp_l=0: the op is applied on the next rising edge, selected by rot_h:
  - 27: S <= wbus_h.
  - 2D: P <= wbus_h.
  - 2F: S <= S-1, modulo 2^SPW (0 wraps to 63).
  - 3B: P <= P+1, modulo 2^SPW (63 wraps to 0).
  - 3D: S <= P and P <= S, swapped in the same edge.
  - 3F: start a count-down run.
    - If S==0: no state change and the FSM stays IDLE (zero-length run).
    - Otherwise: FSM goes to RUN, S holds its value, and stall_h rises in the following cycle.
- modsp_l=0 with any other rot_h value: the decoder never produces this case, so the block treats it as a no-op. The bench flags it with an assertion.
- RUN:
  - stall_h=1 and step_h=1 every cycle.
  - Each edge: S <= S-1.
  - When S==1 at an edge: S <= 0 and FSM -> IDLE. step_h and stall_h drop in the cycle after that edge.
  - Total step_h cycles equal the initial S value, at most CNTMAX.
  - P holds throughout the run.
  - modsp_l and rot_h are ignored while in RUN. The upstream stage keeps the micro-op frozen while stall_h is high.
- step_h and stall_h are registered outputs; they are not combinational from the inputs.
- szero_h is combinational from S.
- Latency:
  - Load, step and swap ops: the result appears on s_h/p_h one cycle after the edge that sampled modsp_l=0.
  - Run: S cycles of stall after entry, plus a 1-cycle entry latency.

Optional Feature:
- Macro: ALK_SP_PARITY_EN.
- When defined:
  - The block keeps an odd-parity bit alongside each of S and P.
  - Each parity bit is generated on every write.
  - The block adds output perr_h (1 bit), registered, which goes high the cycle after the stored parity mismatches the stored latch contents.
  - perr_h stays set until reset.
  - The block adds input pinj_h (1 bit). While it is high, the parity generated on a write is inverted (error injection).
- When undefined: no parity storage, and no perr_h or pinj_h ports.

Test Plan:
- Reset: pulse reset_h mid-cycle -> s_h=0, p_h=0, szero_h=1, stall_h=0 asynchronously, before the next clk edge.
- Load/step: rot 27 with wbus 0x05, then rot 2D with wbus 0x3F, then rot 3B, then rot 2F -> S=5, P=63, then P=0 (wrap), then S=4.
- Swap: S=0x12 and P=0x2A, then rot 3D -> S=0x2A and P=0x12 after one edge.
- Count-down: S=3, then rot 3F -> stall_h and step_h high for exactly 3 cycles, S reads 3,2,1 then 0, FSM back to IDLE, P unchanged. Repeat with S=0 -> stall_h never rises.
- Abort/ignore: start a run with S=10, hold rot 27 with wbus 0x01 during RUN -> S not loaded. Assert reset_h at step 4 -> S=0 and stall_h=0 immediately.
- Parity (ALK_SP_PARITY_EN): load S=0x07 with pinj_h=1 -> perr_h=1 on the next cycle and held until reset. With pinj_h=0 -> perr_h stays 0 through all scenarios above.
